// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider: square wave on clk_out with period div_q and high time high_q.
// Define AUTO_DUTY_EN to derive the high time from the divisor (nearest 50%, longer high for odd).
module prog_clk_div #(
   parameter int CNT_W        = 16,
   parameter int DEFAULT_DIV  = 25,
   parameter int DEFAULT_HIGH = 13
) (
   input  logic             CLK100MHZ,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [CNT_W-1:0] div_in,
   input  logic [CNT_W-1:0] high_in,
   output logic             clk_out,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic             load_ack,
   output logic             cfg_err,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] high_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pend_div;
   logic [CNT_W-1:0] pend_high;
   logic             pend_v;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] load_high;
   logic             load_ok;
   logic             at_end;

   always_comb begin
      cnt_inc = cnt + 1'b1;
      at_end  = (cnt == div_q - 1'b1);
`ifdef AUTO_DUTY_EN
      // Widened add so a divisor of all-ones does not wrap before the shift.
      load_high = CNT_W'(({1'b0, div_in} + 1'b1) >> 1);
      load_ok   = (div_in >= CNT_W'(2));
`else
      load_high = high_in;
      load_ok   = (div_in >= CNT_W'(2)) && (high_in != '0) && (high_in < div_in);
`endif
   end

   assign busy = (state == RUN);

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state     <= IDLE;
         div_q     <= CNT_W'(DEFAULT_DIV);
         high_q    <= CNT_W'(DEFAULT_HIGH);
         cnt       <= '0;
         pend_div  <= '0;
         pend_high <= '0;
         pend_v    <= 1'b0;
         clk_out   <= 1'b0;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         load_ack  <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         load_ack  <= 1'b0;
         cfg_err   <= load && !load_ok;
         case (state)
            IDLE: begin
               // A pending config left over from a stopping boundary is applied here.
               if (load && load_ok) begin
                  div_q    <= div_in;
                  high_q   <= load_high;
                  load_ack <= 1'b1;
                  pend_v   <= 1'b0;
               end else if (pend_v) begin
                  div_q    <= pend_div;
                  high_q   <= pend_high;
                  load_ack <= 1'b1;
                  pend_v   <= 1'b0;
               end
               if (enable) begin
                  state     <= RUN;
                  cnt       <= '0;
                  clk_out   <= 1'b1;
                  rise_tick <= 1'b1;
               end
            end
            RUN: begin
               if (at_end) begin
                  if (pend_v) begin
                     div_q    <= pend_div;
                     high_q   <= pend_high;
                     load_ack <= 1'b1;
                     pend_v   <= 1'b0;
                  end
                  cnt <= '0;
                  if (enable) begin
                     clk_out   <= 1'b1;
                     rise_tick <= 1'b1;
                  end else begin
                     state   <= IDLE;
                     clk_out <= 1'b0;
                  end
               end else begin
                  cnt       <= cnt_inc;
                  clk_out   <= (cnt_inc < high_q);
                  fall_tick <= (cnt_inc == high_q);
               end
               // Placed after the boundary block so a load on the boundary cycle stays pending.
               if (load && load_ok) begin
                  pend_div  <= div_in;
                  pend_high <= load_high;
                  pend_v    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_clk_div.sv
// Lockstep bench for prog_clk_div: expected per-cycle output vectors are queued as stimulus is planned
// and popped one per clock, compared against {clk_out, rise_tick, fall_tick, load_ack, cfg_err, busy}.
module tb_prog_clk_div;

   logic        CLK100MHZ = 1'b0;
   logic        reset;
   logic        enable;
   logic        load;
   logic [15:0] div_in;
   logic [15:0] high_in;
   logic        clk_out;
   logic        rise_tick;
   logic        fall_tick;
   logic        load_ack;
   logic        cfg_err;
   logic        busy;

   prog_clk_div #(.CNT_W(16), .DEFAULT_DIV(25), .DEFAULT_HIGH(13)) dut (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .enable    (enable),
      .load      (load),
      .div_in    (div_in),
      .high_in   (high_in),
      .clk_out   (clk_out),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .load_ack  (load_ack),
      .cfg_err   (cfg_err),
      .busy      (busy)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   typedef struct {
      logic [15:0] div;
      logic [15:0] high;
      bit          man_ok;
      logic [15:0] man_h;
      bit          auto_ok;
      logic [15:0] auto_h;
   } vec_t;

   vec_t       vecs [10];
   logic [5:0] exp_q [$];
   int         checks   = 0;
   int         failures = 0;
   int         tick_n   = 0;
   string      tag      = "init";

   function automatic logic [15:0] eff_h(input logic [15:0] d, input logic [15:0] h);
`ifdef AUTO_DUTY_EN
      return 16'((17'(d) + 17'd1) >> 1);
`else
      return h;
`endif
   endfunction

   task automatic push_period(input int p, input int h, input bit ack, input int err_idx, input int len);
      logic [5:0] v;
      for (int i = 0; i < len; i++) begin
         v = {i < h, i == 0, i == h, ack && (i == 0), i == err_idx, 1'b1};
         exp_q.push_back(v);
      end
   endtask

   task automatic push_zero(input bit ack, input bit err);
      exp_q.push_back({3'b000, ack, err, 1'b0});
   endtask

   task automatic check_one();
      logic [5:0] got;
      logic [5:0] exp;
      got = {clk_out, rise_tick, fall_tick, load_ack, cfg_err, busy};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s queue_empty tick=%0d got=%b", tag, tick_n, got);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            failures++;
            $display("FAIL %s tick=%0d got=%b exp=%b", tag, tick_n, got, exp);
         end
      end
   endtask

   task automatic tick(input bit en, input bit ld, input logic [15:0] d, input logic [15:0] h, input bit rst);
      reset   = rst;
      enable  = en;
      load    = ld;
      div_in  = d;
      high_in = h;
      @(posedge CLK100MHZ);
      #1;
      tick_n++;
      check_one();
   endtask

   task automatic run_period(input int p, input int ld_idx, input logic [15:0] d, input logic [15:0] h);
      for (int i = 0; i < p; i++) tick(1'b1, i == ld_idx, d, h, 1'b0);
   endtask

   initial begin
      int          cur_p;
      int          cur_h;
      bit          ack;
      bit          ok;
      logic [15:0] nh;
      logic [15:0] h6;
      logic [15:0] h4;
      logic [15:0] h12;
      logic [15:0] h8;

      vecs[0] = '{16'd1,  16'd1,  1'b0, 16'd0, 1'b0, 16'd0};
      vecs[1] = '{16'd10, 16'd0,  1'b0, 16'd0, 1'b1, 16'd5};
      vecs[2] = '{16'd10, 16'd10, 1'b0, 16'd0, 1'b1, 16'd5};
      vecs[3] = '{16'd0,  16'd0,  1'b0, 16'd0, 1'b0, 16'd0};
      vecs[4] = '{16'd6,  16'd3,  1'b1, 16'd3, 1'b1, 16'd3};
      vecs[5] = '{16'd2,  16'd1,  1'b1, 16'd1, 1'b1, 16'd1};
      vecs[6] = '{16'd7,  16'd6,  1'b1, 16'd6, 1'b1, 16'd4};
      vecs[7] = '{16'd3,  16'd3,  1'b0, 16'd0, 1'b1, 16'd2};
      vecs[8] = '{16'd5,  16'd1,  1'b1, 16'd1, 1'b1, 16'd3};
      vecs[9] = '{16'd9,  16'd4,  1'b1, 16'd4, 1'b1, 16'd5};

      reset = 1'b1; enable = 1'b0; load = 1'b0; div_in = '0; high_in = '0;

      tag = "reset";
      repeat (2) begin push_zero(0, 0); tick(0, 0, 0, 0, 1); end
      tag = "idle";
      repeat (2) begin push_zero(0, 0); tick(0, 0, 0, 0, 0); end

      tag = "default_period";
      push_period(25, 13, 0, -1, 25);
      run_period(25, -1, 0, 0);

      // enable goes low from the edge where cnt=3; the period still runs its full 25 cycles
      tag = "stop_mid";
      push_period(25, 13, 0, -1, 25);
      for (int i = 0; i < 25; i++) tick(i < 4, 0, 0, 0, 0);
      push_zero(0, 0); tick(0, 0, 0, 0, 0);
      push_zero(0, 0); tick(0, 0, 0, 0, 0);

      tag = "restart_midload";
      push_period(25, 13, 0, -1, 25);
      run_period(25, 5, 16'd10, 16'd5);
      push_period(10, eff_h(16'd10, 16'd5), 1, -1, 10);
      push_period(10, eff_h(16'd10, 16'd5), 0, -1, 10);
      run_period(10, -1, 0, 0);
      run_period(10, -1, 0, 0);

      tag = "table";
      cur_p = 10; cur_h = eff_h(16'd10, 16'd5); ack = 0;
      for (int k = 0; k < 10; k++) begin
`ifdef AUTO_DUTY_EN
         ok = vecs[k].auto_ok; nh = vecs[k].auto_h;
`else
         ok = vecs[k].man_ok;  nh = vecs[k].man_h;
`endif
         push_period(cur_p, cur_h, ack, ok ? -1 : 1, cur_p);
         run_period(cur_p, 1, vecs[k].div, vecs[k].high);
         ack = ok;
         if (ok) begin cur_p = vecs[k].div; cur_h = nh; end
      end
      push_period(cur_p, cur_h, ack, -1, cur_p);
      run_period(cur_p, -1, 0, 0);

      tag = "two_loads";
      h6 = eff_h(16'd6, 16'd2);
      push_period(cur_p, cur_h, 0, -1, cur_p);
      for (int i = 0; i < cur_p; i++) begin
         if (i == 1)      tick(1, 1, 16'd8, 16'd4, 0);
         else if (i == 2) tick(1, 1, 16'd6, 16'd2, 0);
         else             tick(1, 0, 0, 0, 0);
      end
      push_period(6, h6, 1, -1, 6);
      run_period(6, -1, 0, 0);

      tag = "boundary_load";
      h4 = eff_h(16'd4, 16'd2);
      push_period(6, h6, 0, -1, 6);
      run_period(6, 0, 16'd4, 16'd2);
      push_period(4, h4, 1, -1, 4);
      run_period(4, -1, 0, 0);

      tag = "reset_mid";
      h12 = eff_h(16'd12, 16'd6);
      push_period(4, h4, 0, -1, 4);
      run_period(4, 1, 16'd12, 16'd6);
      push_period(12, h12, 1, -1, 8);
      run_period(8, -1, 0, 0);
      push_zero(0, 0); tick(1, 0, 0, 0, 1);
      push_period(25, 13, 0, -1, 25);
      run_period(25, -1, 0, 0);
      push_zero(0, 0); tick(0, 0, 0, 0, 0);

      tag = "idle_load";
      h8 = eff_h(16'd8, 16'd3);
      push_zero(0, 1); tick(0, 1, 16'd1, 16'd0, 0);
      push_zero(1, 0); tick(0, 1, 16'd8, 16'd3, 0);
      push_period(8, h8, 0, -1, 8);
      run_period(8, -1, 0, 0);
      push_zero(0, 0); tick(0, 0, 0, 0, 0);

      tag = "drain";
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s leftover got=%0d exp=0", tag, exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
